// File: rtl/calculator_display.sv
// calculator_display: converts a 14-bit signed-magnitude result to BCD with a
// sequential shift-add-3 engine and drives a multiplexed, active-low,
// common-anode 4-digit seven-segment display.
// Optional feature macro: CALC_DISPLAY_BLANK_ZEROS_EN (blank leading zeros).
module calculator_display #(
  parameter int REFRESH_OVERFLOW = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic        neg,
  input  logic        load,
  output logic        ready,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CNT_W = (REFRESH_OVERFLOW > 2) ? $clog2(REFRESH_OVERFLOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_OVERFLOW - 1);

  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [13:0] mag_reg;
  logic        neg_reg;
  logic        oor_reg;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  shift_cnt;

  logic [15:0] disp_digits;
  logic        disp_neg;
  logic        disp_oor;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [1:0]       idx_next;
  logic             refresh_wrap;

  // Standard seven-segment encoding of a BCD digit, {g,f,e,d,c,b,a} active low
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // Glyph shown at one digit position given the latched display contents
  function automatic logic [6:0] position_glyph(input logic [1:0]  pos,
                                                input logic [15:0] digits,
                                                input logic        n,
                                                input logic        o);
    logic [6:0] g;
    logic [3:0] d;
    d = digits[pos*4 +: 4];
    g = digit_glyph(d);
    if (o) begin
      g = GLYPH_DASH;
    end else if (pos == 2'd3 && n) begin
      g = GLYPH_DASH;
    end else begin
`ifdef CALC_DISPLAY_BLANK_ZEROS_EN
      case (pos)
        2'd3:    if (digits[15:12] == 4'd0) g = GLYPH_BLANK;
        2'd2:    if (digits[15:8] == 8'd0) g = GLYPH_BLANK;
        2'd1:    if (digits[15:4] == 12'd0) g = GLYPH_BLANK;
        default: g = digit_glyph(d);
      endcase
`else
      g = digit_glyph(d);
`endif
    end
    return g;
  endfunction

  assign ready = (state == IDLE);

  // Converter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Converter next-state: fixed 14 shifts then one cycle to publish the result
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (shift_cnt == 4'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add 3 to every BCD nibble that is 5 or more before the next shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Operand capture with range check, then the double-dabble shift datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_reg   <= '0;
      neg_reg   <= 1'b0;
      oor_reg   <= 1'b0;
      bcd       <= '0;
      shift_cnt <= '0;
    end else if (state == IDLE && load) begin
      mag_reg   <= value;
      neg_reg   <= neg;
      oor_reg   <= neg ? (value > 14'd999) : (value > 14'd9999);
      bcd       <= '0;
      shift_cnt <= 4'd14;
    end else if (state == SHIFT) begin
      bcd       <= {bcd_adj[14:0], mag_reg[13]};
      mag_reg   <= {mag_reg[12:0], 1'b0};
      shift_cnt <= shift_cnt - 4'd1;
    end
  end

  // Display registers only take a finished conversion, never partial results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_digits <= '0;
      disp_neg    <= 1'b0;
      disp_oor    <= 1'b0;
    end else if (state == DONE) begin
      disp_digits <= bcd;
      disp_neg    <= neg_reg;
      disp_oor    <= oor_reg;
    end
  end

  assign refresh_wrap = (refresh_cnt == CNT_LAST);
  assign idx_next     = refresh_wrap ? digit_idx + 2'd1 : digit_idx;

  // Refresh timer and digit index for the time-multiplexed anodes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else begin
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + CNT_W'(1);
      digit_idx   <= idx_next;
    end
  end

  // Registered pin drivers; seg tracks display contents one cycle behind
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= 7'b1000000;
      an  <= 4'b1110;
    end else begin
      seg <= position_glyph(idx_next, disp_digits, disp_neg, disp_oor);
      an  <= ~(4'b0001 << idx_next);
    end
  end

endmodule

// File: tb/tb_calculator_display.sv
// tb_calculator_display: directed, table-driven bench for calculator_display.
// Build with CALC_DISPLAY_BLANK_ZEROS_EN defined to check the blanking variant.
module tb_calculator_display;

  localparam int R = 4;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef CALC_DISPLAY_BLANK_ZEROS_EN
  localparam logic [6:0] ZB = BLANK;
`else
  localparam logic [6:0] ZB = G0;
`endif

  typedef struct {
    string            name;
    logic [13:0]      value;
    logic             neg;
    logic [3:0][6:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] value;
  logic        neg;
  logic        load;
  logic        ready;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[10];

  calculator_display #(.REFRESH_OVERFLOW(R)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .neg   (neg),
    .load  (load),
    .ready (ready),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pulse load for one sampling edge; returns at the negedge after that edge
  task automatic applyStimulus(input logic [13:0] v, input logic n);
    @(negedge clk);
    value = v;
    neg   = n;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (ready !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_ready_wait"}, 32'(ready), 32'd1);
  endtask

  // Visit each anode position in turn and compare the glyph shown there
  task automatic scan_display(input string name, input logic [3:0][6:0] exp);
    for (int p = 0; p < 4; p++) begin
      logic [3:0] want;
      int k;
      want = ~(4'b0001 << p);
      k = 0;
      while (an !== want && k < 4 * R + 4) begin
        @(negedge clk);
        k++;
      end
      checkOutput($sformatf("%s_an%0d", name, p), 32'(an), 32'(want));
      checkOutput($sformatf("%s_seg%0d", name, p), 32'(seg), 32'(exp[p]));
    end
  endtask

  function automatic int lit_position(input logic [3:0] a);
    int pos = -1;
    for (int p = 0; p < 4; p++) begin
      logic [3:0] want;
      want = ~(4'b0001 << p);
      if (a === want) pos = p;
    end
    return pos;
  endfunction

  initial begin
    int busy_hits;
    int pos;

    vecs[0] = '{name: "p1234",  value: 14'd1234,  neg: 1'b0, exp: {G1, G2, G3, G4}};
    vecs[1] = '{name: "n42",    value: 14'd42,    neg: 1'b1, exp: {DASH, ZB, G4, G2}};
    vecs[2] = '{name: "p10000", value: 14'd10000, neg: 1'b0, exp: {DASH, DASH, DASH, DASH}};
    vecs[3] = '{name: "n1000",  value: 14'd1000,  neg: 1'b1, exp: {DASH, DASH, DASH, DASH}};
    vecs[4] = '{name: "n999",   value: 14'd999,   neg: 1'b1, exp: {DASH, G9, G9, G9}};
    vecs[5] = '{name: "p9999",  value: 14'd9999,  neg: 1'b0, exp: {G9, G9, G9, G9}};
    vecs[6] = '{name: "p7",     value: 14'd7,     neg: 1'b0, exp: {ZB, ZB, ZB, G7}};
    vecs[7] = '{name: "p16383", value: 14'd16383, neg: 1'b0, exp: {DASH, DASH, DASH, DASH}};
    vecs[8] = '{name: "n0",     value: 14'd0,     neg: 1'b1, exp: {DASH, ZB, ZB, G0}};
    vecs[9] = '{name: "p560",   value: 14'd560,   neg: 1'b0, exp: {ZB, G5, G6, G0}};

    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    neg   = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_an", 32'(an), 32'h0000000e);
    checkOutput("rst_seg", 32'(seg), 32'(G0));

    // Anode rotation after reset release: one step every R cycles
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rot_hold", 32'(an), 32'h0000000e);
    @(negedge clk);
    checkOutput("rot_an1", 32'(an), 32'h0000000d);
    checkOutput("rot_seg1", 32'(seg), 32'(ZB));
    repeat (R) @(negedge clk);
    checkOutput("rot_an2", 32'(an), 32'h0000000b);
    repeat (R) @(negedge clk);
    checkOutput("rot_an3", 32'(an), 32'h00000007);
    checkOutput("rot_seg3", 32'(seg), 32'(ZB));
    repeat (R) @(negedge clk);
    checkOutput("rot_an0", 32'(an), 32'h0000000e);
    checkOutput("rot_seg0", 32'(seg), 32'(G0));

    // Table-driven conversions with busy-window timing
    for (int i = 0; i < 10; i++) begin
      wait_ready(vecs[i].name);
      applyStimulus(vecs[i].value, vecs[i].neg);
      checkOutput({vecs[i].name, "_busyN"}, 32'(ready), 32'd0);
      busy_hits = 0;
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        if (ready !== 1'b0) busy_hits++;
      end
      checkOutput({vecs[i].name, "_busy_window"}, 32'(busy_hits), 32'd0);
      @(negedge clk);
      checkOutput({vecs[i].name, "_readyN15"}, 32'(ready), 32'd1);
      @(negedge clk);
      pos = lit_position(an);
      if (pos < 0) checkOutput({vecs[i].name, "_lit_pos"}, 32'(an), 32'h0000000e);
      else checkOutput({vecs[i].name, "_seg_immediate"}, 32'(seg), 32'(vecs[i].exp[pos]));
      scan_display(vecs[i].name, vecs[i].exp);
    end

    // Loads during conversion are dropped; load at N+15 dropped, N+16 accepted
    wait_ready("ign");
    applyStimulus(14'd5, 1'b0);
    repeat (4) @(negedge clk);
    value = 14'd9999;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    checkOutput("ign_busyN5", 32'(ready), 32'd0);
    repeat (9) @(negedge clk);
    load  = 1'b1;
    @(negedge clk);
    checkOutput("ign_readyN15", 32'(ready), 32'd1);
    @(negedge clk);
    load  = 1'b0;
    checkOutput("ign_acceptN16", 32'(ready), 32'd0);
    pos = lit_position(an);
    if (pos < 0) checkOutput("ign_lit_pos", 32'(an), 32'h0000000e);
    else checkOutput("ign_seg_five", 32'(seg), 32'(({ZB, ZB, ZB, G5} >> (7 * pos)) & 28'h7f));
    wait_ready("ign2");
    repeat (2) @(negedge clk);
    scan_display("ign_9999", {G9, G9, G9, G9});

    // Asynchronous reset in the middle of a conversion
    wait_ready("rstmid");
    applyStimulus(14'd1234, 1'b0);
    repeat (7) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstmid_ready", 32'(ready), 32'd1);
    checkOutput("rstmid_an", 32'(an), 32'h0000000e);
    checkOutput("rstmid_seg", 32'(seg), 32'(G0));
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("rstmid_ready_after", 32'(ready), 32'd1);
    scan_display("rstmid_disp", {ZB, ZB, ZB, G0});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/calculator_display.md
# calculator_display

Output-side counterpart to the calculator's input conditioning. Accepts a binary result plus sign from the calculator core, converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a time-multiplexed, active-low, common-anode 4-digit seven-segment display. Sits between the calculator datapath and the board's display pins.

## Interface
- REFRESH_OVERFLOW, 100000: clock cycles each digit is lit before advancing (1 kHz digit rate at 100 MHz); legal ≥ 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- value  in  14  unsigned magnitude of the result.
- neg  in  1  result is negative.
- load  in  1  request to convert and display value/neg; accepted only when ready=1.
- ready  out  1  converter idle, load will be accepted.
- seg  out  7  {g,f,e,d,c,b,a}, active low.
- an  out  4  digit enables, active low; an[0] = ones digit, an[3] = thousands digit.

## Operation
- Converter FSM states: IDLE, SHIFT, DONE.
- IDLE: ready=1. On load=1, register value/neg, clear the BCD scratch and set the shift counter to 14; go to SHIFT.
- Range check happens at capture: out of range when (neg=0 and value>9999) or (neg=1 and value>999). An out-of-range flag is registered with the operands.
- SHIFT: ready=0. For 14 cycles, add 3 to each BCD nibble ≥5, then shift left one bit of the magnitude. After the 14th shift, go to DONE.
- DONE: ready=0. Copy the four BCD nibbles, neg and the range flag into the display registers; go to IDLE.
- load while ready=0 is ignored; it is not queued.
- Display registers change only in DONE, so the display never shows partial results.
- Glyph per digit position:
  - out of range: all four positions show '-' (7'b0111111).
  - neg=1: position 3 shows '-'; positions 2..0 show the BCD digits.
  - otherwise: positions 3..0 show the BCD digits.
- Digit encodings 0..9 are standard; 0 = 7'b1000000, 8 = 7'b0000000. Blank = 7'b1111111.
- Mux: refresh counter runs 0..REFRESH_OVERFLOW-1. At wrap, the digit index advances 0→1→2→3→0.
- an has exactly one bit low, at the current index. seg is the glyph for that index.

## Timing
- Reset values:
  - FSM: IDLE, ready=1.
  - Display registers hold 0, neg=0, in range.
  - Refresh counter 0, index 0, so an=4'b1110 and seg=7'b1000000.
- load sampled high at edge N (ready=1):
  - ready=0 from N through N+15.
  - Display registers updated at edge N+15.
  - ready=1 again after N+15, so the next load can be accepted at edge N+16.
  - A load at N+15 is ignored.
- seg and an are registered outputs. They change only on a refresh wrap or a display-register update.
- A display-register update during a digit's lit period changes seg on the next cycle, without waiting for the wrap.
- Asynchronous reset mid-conversion abandons the conversion. Display and outputs return to their reset values immediately.

## Configuration
- CALC_DISPLAY_BLANK_ZEROS_EN:
  - Defined: leading zeros are blanked. Position 3 is blank when its digit is 0 and neg=0. Position 2 is blank when positions 3 and 2 both hold zero digits. Position 1 follows the same rule. Position 0 is never blanked. With neg=1, position 3 still shows '-' and positions 2..1 blank leading zeros.
  - Undefined: all four digits always shown (e.g. "0042").
  - Out-of-range display is unaffected by the macro.

## Test plan
- Reset, REFRESH_OVERFLOW=4 → an=1110, seg=1000000; an steps 1101, 1011, 0111, 1110 every 4 cycles.
- load value=1234 neg=0 at edge N → ready low N..N+15; after N+15, positions 3..0 show 1,2,3,4 (seg 1111001, 0100100, 0110000, 0011001).
- load value=42 neg=1 → positions 3..0 show '-', 0, 4, 2. With CALC_DISPLAY_BLANK_ZEROS_EN, position 2 is blank.
- load value=10000 neg=0, and separately value=1000 neg=1 → all positions 0111111.
- Second load at N+5 with value=9999 during conversion of 5 → display shows 0005 / "5"; a load at N+16 with 9999 then shows 9999.
- Assert reset at N+7 mid-conversion → ready=1, an=1110, seg=1000000 immediately; the display is not updated after reset release.
